// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the flow-controlled FIFO.
// The FIFO_FWFT_EN macro selects first-word-fall-through reads in fifo_flow_ctrl.
package fifo_pkg;

  localparam int unsigned DEF_DATA_SIZE = 32'd10;
  localparam int unsigned DEF_ADDR_SIZE = 32'd3;

  // Occupancy must represent 0..DEPTH inclusive, hence one extra bit.
  function automatic int unsigned count_width(input int unsigned addr_size);
    return addr_size + 32'd1;
  endfunction

  typedef logic [1:0] err_cause_t;
  localparam err_cause_t ERR_NONE = 2'd0;
  localparam err_cause_t ERR_OVF  = 2'd1;
  localparam err_cause_t ERR_UDF  = 2'd2;

endpackage

// File: rtl/fifo_flow_ctrl_if.sv
// Push/pop, threshold and status bundle of one virtual-channel FIFO.
// master = upstream/arbiter side, slave = the FIFO itself.
interface fifo_flow_ctrl_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
  parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE
) ();

  logic                                write;
  logic                                read;
  logic [DATA_SIZE-1:0]                data_in_push;
  logic [count_width(ADDR_SIZE)-1:0]   thr_high;
  logic [count_width(ADDR_SIZE)-1:0]   thr_low;
  logic [DATA_SIZE-1:0]                data_out_pop;
  logic                                valid_out;
  logic [count_width(ADDR_SIZE)-1:0]   fifo_count;
  logic                                fifo_empty;
  logic                                fifo_full;
  logic                                almost_empty;
  logic                                almost_full;
  logic                                fifo_pause;
  logic                                fifo_error;

  modport master (
    output write, read, data_in_push, thr_high, thr_low,
    input  data_out_pop, valid_out, fifo_count, fifo_empty, fifo_full,
           almost_empty, almost_full, fifo_pause, fifo_error
  );

  modport slave (
    input  write, read, data_in_push, thr_high, thr_low,
    output data_out_pop, valid_out, fifo_count, fifo_empty, fifo_full,
           almost_empty, almost_full, fifo_pause, fifo_error
  );

endinterface

// File: rtl/fifo_flow_ctrl_mem.sv
// DEPTH x DATA_SIZE dual-port register array: synchronous write, asynchronous read.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
  parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [ADDR_SIZE-1:0] i_waddr,
  input  logic [DATA_SIZE-1:0] i_wdata,
  input  logic [ADDR_SIZE-1:0] i_raddr,
  output logic [DATA_SIZE-1:0] o_rdata
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_SIZE;

  logic [DATA_SIZE-1:0] r_mem [DEPTH];

  // Storage write; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_flow_ctrl.sv
// Synchronous FIFO with programmable almost-full/empty thresholds, pause hysteresis and sticky error.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered 1-cycle read path.
module fifo_flow_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
  parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic           clk,
  input  logic           reset,
  fifo_flow_ctrl_if.slave bus
);

  localparam int unsigned   CW      = count_width(ADDR_SIZE);
  localparam logic [CW-1:0] DEPTH_C = {1'b1, {ADDR_SIZE{1'b0}}};
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

  logic [ADDR_SIZE-1:0] r_wr_ptr;
  logic [ADDR_SIZE-1:0] r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_empty;
  logic                 r_full;
  logic                 r_aempty;
  logic                 r_afull;
  logic                 r_pause;
  logic                 r_error;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_ovf;
  logic                 w_udf;
  logic                 w_mem_we;
  logic [ADDR_SIZE-1:0] w_wr_ptr_nxt;
  logic [ADDR_SIZE-1:0] w_rd_ptr_nxt;
  logic [CW-1:0]        w_count_nxt;
  logic                 w_pause_nxt;
  logic [DATA_SIZE-1:0] w_rdata;

  // Accept/reject decisions; a read frees a slot in the same edge so a full FIFO still takes a write.
  always_comb begin
    w_push = bus.write && (!r_full || bus.read);
    w_pop  = bus.read && !r_empty;
    w_ovf  = bus.write && r_full && !bus.read;
    w_udf  = bus.read && r_empty;
  end

  // Next pointers, occupancy and pause state.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    w_pause_nxt  = r_pause;
    if (w_push) begin
      w_wr_ptr_nxt = r_wr_ptr + ADDR_SIZE'(1'b1);
    end else begin
      w_wr_ptr_nxt = r_wr_ptr;
    end
    if (w_pop) begin
      w_rd_ptr_nxt = r_rd_ptr + ADDR_SIZE'(1'b1);
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
    end
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1'b1);
      2'b01:   w_count_nxt = r_count - CW'(1'b1);
      default: w_count_nxt = r_count;
    endcase
    // Set is tested first so it wins when the thresholds overlap.
    if (w_count_nxt >= bus.thr_high) begin
      w_pause_nxt = 1'b1;
    end else if (w_count_nxt <= bus.thr_low) begin
      w_pause_nxt = 1'b0;
    end else begin
      w_pause_nxt = r_pause;
    end
  end

  // Pointers, count and flags, all reflecting the post-edge occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= {ADDR_SIZE{1'b0}};
      r_rd_ptr <= {ADDR_SIZE{1'b0}};
      r_count  <= ZERO_C;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_aempty <= 1'b1;
      r_afull  <= 1'b0;
      r_pause  <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_empty  <= (w_count_nxt == ZERO_C);
      r_full   <= (w_count_nxt == DEPTH_C);
      r_aempty <= (w_count_nxt <= bus.thr_low);
      r_afull  <= (w_count_nxt >= bus.thr_high);
      r_pause  <= w_pause_nxt;
      r_error  <= r_error || w_ovf || w_udf;
    end
  end

  // A push coinciding with reset is discarded along with the pointer update.
  assign w_mem_we = w_push && reset;

  fifo_mem #(
    .DATA_SIZE (DATA_SIZE),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.data_in_push),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

`ifdef FIFO_FWFT_EN
  assign bus.data_out_pop = w_rdata;
  assign bus.valid_out    = !r_empty;
`else
  logic [DATA_SIZE-1:0] r_data;
  logic                 r_valid;

  // Registered read port; on a full read+write the array still holds the oldest word at this edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_data  <= {DATA_SIZE{1'b0}};
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_pop;
      if (w_pop) begin
        r_data <= w_rdata;
      end else begin
        r_data <= r_data;
      end
    end
  end

  assign bus.data_out_pop = r_data;
  assign bus.valid_out    = r_valid;
`endif

  assign bus.fifo_count   = r_count;
  assign bus.fifo_empty   = r_empty;
  assign bus.fifo_full    = r_full;
  assign bus.almost_empty = r_aempty;
  assign bus.almost_full  = r_afull;
  assign bus.fifo_pause   = r_pause;
  assign bus.fifo_error   = r_error;

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Directed bench for fifo_flow_ctrl (DEPTH 8, thr_high 6, thr_low 2).
// Compile with FIFO_FWFT_EN to exercise the fall-through read path instead.
module tb_fifo_flow_ctrl;
  import fifo_pkg::*;

  localparam int unsigned DW = 32'd10;
  localparam int unsigned AW = 32'd3;

  logic       clk = 1'b0;
  logic       reset;
  int         n_pass = 0;
  int         n_fail = 0;
  int         n_total = 0;
  err_cause_t exp_cause;

  fifo_flow_ctrl_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) bus ();

  fifo_flow_ctrl #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic r, input logic [9:0] d);
    bus.write        = w;
    bus.read         = r;
    bus.data_in_push = d;
    @(posedge clk);
    #1;
    bus.write = 1'b0;
    bus.read  = 1'b0;
  endtask

  task automatic chk_state(input string tag, input int cnt, input logic e, input logic f,
                           input logic ae, input logic af, input logic p, input logic er);
    chk({tag, ".count"}, 32'(bus.fifo_count), 32'(cnt));
    chk({tag, ".empty"}, 32'(bus.fifo_empty), 32'(e));
    chk({tag, ".full"}, 32'(bus.fifo_full), 32'(f));
    chk({tag, ".aempty"}, 32'(bus.almost_empty), 32'(ae));
    chk({tag, ".afull"}, 32'(bus.almost_full), 32'(af));
    chk({tag, ".pause"}, 32'(bus.fifo_pause), 32'(p));
    chk({tag, ".error"}, 32'(bus.fifo_error), 32'(er));
  endtask

  task automatic chk_rd(input string tag, input logic v, input logic [9:0] d);
    chk({tag, ".valid"}, 32'(bus.valid_out), 32'(v));
    chk({tag, ".data"}, 32'(bus.data_out_pop), 32'(d));
  endtask

  initial begin
    reset            = 1'b0;
    bus.write        = 1'b0;
    bus.read         = 1'b0;
    bus.data_in_push = 10'h000;
    bus.thr_high     = 4'd6;
    bus.thr_low      = 4'd2;
    exp_cause        = ERR_NONE;
    repeat (6) @(posedge clk);
    #1;
    chk_state("in_reset", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 10'h000);
    chk_state("after_reset", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("after_reset.valid", 32'(bus.valid_out), 32'd0);

`ifdef FIFO_FWFT_EN
    cyc(1'b1, 1'b0, 10'h0BB);
    chk_rd("fwft_wr", 1'b1, 10'h0BB);
    chk_state("fwft_wr", 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 10'h000);
    chk_rd("fwft_hold", 1'b1, 10'h0BB);
    cyc(1'b0, 1'b1, 10'h000);
    chk("fwft_rd.valid", 32'(bus.valid_out), 32'd0);
    chk_state("fwft_rd", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`else
    // Fill: almost_empty drops at 3, almost_full/pause rise at 6, full at 8.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, 10'h100 - 10'(i));
      chk_state($sformatf("fill%0d", i), i, 1'b0, (i == 8), (i <= 2), (i >= 6), (i >= 6), 1'b0);
    end
    exp_cause = ERR_OVF;
    cyc(1'b1, 1'b0, 10'h0DD);
    chk_state("overflow", 8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, (exp_cause != ERR_NONE));

    // Drain: oldest first; pause holds down to 3 and clears at 2.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 10'h000);
      chk_rd($sformatf("drain%0d", i), 1'b1, 10'h0FF - 10'(i));
      chk_state($sformatf("drain%0d", i), 7 - i, (i == 7), 1'b0, ((7 - i) <= 2),
                ((7 - i) >= 6), ((7 - i) >= 3), 1'b1);
    end
    cyc(1'b0, 1'b0, 10'h000);
    chk_rd("drain_idle", 1'b0, 10'h0F8);

    // Read+write on empty: push lands, pop underflows.
    reset = 1'b0;
    cyc(1'b0, 1'b0, 10'h000);
    reset = 1'b1;
    chk("rst2.error", 32'(bus.fifo_error), 32'd0);
    exp_cause = ERR_UDF;
    cyc(1'b1, 1'b1, 10'h0EE);
    chk_rd("udf_rw", 1'b0, 10'h000);
    chk_state("udf_rw", 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, (exp_cause != ERR_NONE));
    cyc(1'b0, 1'b1, 10'h000);
    chk_rd("udf_next", 1'b1, 10'h0EE);
    chk("udf_next.count", 32'(bus.fifo_count), 32'd0);

    // Reset mid-burst discards the in-flight push.
    cyc(1'b1, 1'b0, 10'h3A0);
    cyc(1'b1, 1'b0, 10'h3A1);
    reset = 1'b0;
    cyc(1'b1, 1'b0, 10'h3FF);
    reset = 1'b1;
    chk_state("mid_rst", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_rd("mid_rst", 1'b0, 10'h000);
    cyc(1'b0, 1'b0, 10'h000);
    chk("mid_rst_idle.count", 32'(bus.fifo_count), 32'd0);

    // Full with simultaneous read+write: count pinned at 8, oldest words out.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 10'h010 + 10'(i));
    end
    chk_state("refill", 8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 10'h0CC);
      chk_rd($sformatf("full_rw%0d", i), 1'b1, 10'h010 + 10'(i));
      chk_state($sformatf("full_rw%0d", i), 8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 10'h000);
      chk_rd($sformatf("tail%0d", i), 1'b1, (i < 4) ? (10'h014 + 10'(i)) : 10'h0CC);
      chk($sformatf("tail%0d.count", i), 32'(bus.fifo_count), 32'(7 - i));
    end
    cyc(1'b0, 1'b0, 10'h000);
    chk("tail_idle.valid", 32'(bus.valid_out), 32'd0);
    chk("tail_idle.empty", 32'(bus.fifo_empty), 32'd1);
    chk("tail_idle.error", 32'(bus.fifo_error), 32'd0);

    // Overlapping thresholds: set wins when count is both >= high and <= low.
    bus.thr_high = 4'd1;
    bus.thr_low  = 4'd3;
    cyc(1'b1, 1'b0, 10'h055);
    chk_state("ovlp1", 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 10'h000);
    chk_state("ovlp0", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_rd("ovlp0", 1'b1, 10'h055);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
